// File: rtl/ncr5380_mt.sv
// NCR5380-style SCSI initiator with a multi-target bus mux and pseudo-DMA handshake.
// Define NCR5380_MT_IRQ_EN to build the interrupt flag and the registered irq output.
module ncr5380_mt #(
    parameter int unsigned NUM_TGT   = 2,
    parameter logic [7:0]  IDLE_DATA = 8'h55
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce,
    input  logic                   bus_cs,
    input  logic                   bus_we,
    input  logic [2:0]             bus_rs,
    input  logic                   dack,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   irq,
    output logic                   drq,
    input  logic [NUM_TGT-1:0]     tgt_bsy,
    input  logic [NUM_TGT-1:0]     tgt_msg,
    input  logic [NUM_TGT-1:0]     tgt_cd,
    input  logic [NUM_TGT-1:0]     tgt_io,
    input  logic [NUM_TGT-1:0]     tgt_req,
    input  logic [8*NUM_TGT-1:0]   tgt_dout,
    output logic                   scsi_rst,
    output logic                   scsi_sel,
    output logic                   scsi_atn,
    output logic                   scsi_ack,
    output logic [7:0]             scsi_dout,
    output logic [2:0]             act_tgt
);

    typedef enum logic [1:0] {
        D_IDLE = 2'd0,
        D_WAIT = 2'd1,
        D_ACK  = 2'd2
    } dstate_t;

    dstate_t     state;
    dstate_t     state_n;

    logic [7:0]  mr;
    logic        icr_rst;
    logic [4:0]  icr_lo;
    logic [3:0]  tcr;
    logic        dma_en;
    logic        ack_q;
    logic        eodma;
    logic        busy_err;
    logic        irq_flag;

    logic        dma_wr_q, dma_rd_q, reg_wr_q, reg_rd_q;
    logic        req_q, bsy_q;

    logic        dma_wr_l, dma_rd_l, reg_wr_l, reg_rd_l;
    logic        dma_wr, dma_rd, reg_wr, reg_rd;

    logic        any_bsy;
    logic        sig_msg, sig_cd, sig_io, sig_req;
    logic [7:0]  din;
    logic        pmatch;
    logic        req_rise;
    logic        mismatch;
    logic        bsy_loss;
    logic        rd7_clr;
    logic        dma_start;
    logic        out_en;
    logic        csr_bsy;
    logic [7:0]  csr;
    logic [7:0]  bsr;

    // Host strobe edge detection with priority dma_wr > dma_rd > reg_wr
    always_comb begin
        dma_wr_l = dack & bus_we;
        dma_rd_l = dack & ~bus_we;
        reg_wr_l = bus_cs & bus_we;
        reg_rd_l = bus_cs & ~bus_we & ~dack;
        dma_wr   = dma_wr_l & ~dma_wr_q;
        dma_rd   = dma_rd_l & ~dma_rd_q & ~dma_wr;
        reg_wr   = reg_wr_l & ~reg_wr_q & ~dma_wr & ~dma_rd;
        reg_rd   = reg_rd_l & ~reg_rd_q;
    end

    // Lowest-index busy target owns the muxed bus; scanning downward leaves the lowest
    always_comb begin
        act_tgt = 3'd0;
        sig_msg = 1'b0;
        sig_cd  = 1'b0;
        sig_io  = 1'b0;
        sig_req = 1'b0;
        din     = IDLE_DATA;
        for (int i = int'(NUM_TGT) - 1; i >= 0; i--) begin
            if (tgt_bsy[i]) begin
                act_tgt = 3'(i);
                sig_msg = tgt_msg[i];
                sig_cd  = tgt_cd[i];
                sig_io  = tgt_io[i];
                sig_req = tgt_req[i];
                din     = tgt_dout[8*i +: 8];
            end
        end
    end

    always_comb begin
        any_bsy   = |tgt_bsy;
        pmatch    = (tcr[2:0] == {sig_msg, sig_cd, sig_io});
        req_rise  = sig_req & ~req_q;
        mismatch  = req_rise & dma_en & ~pmatch;
        bsy_loss  = bsy_q & ~any_bsy & mr[2];
        rd7_clr   = reg_rd & (bus_rs == 3'd7);
        dma_start = reg_wr & (bus_rs >= 3'd5) & mr[1];
    end

    // Register file, DMA enable, status flags and ACK timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_wr_q  <= 1'b0;
            dma_rd_q  <= 1'b0;
            reg_wr_q  <= 1'b0;
            reg_rd_q  <= 1'b0;
            req_q     <= 1'b0;
            bsy_q     <= 1'b0;
            mr        <= 8'h00;
            icr_rst   <= 1'b0;
            icr_lo    <= 5'h00;
            tcr       <= 4'h0;
            scsi_dout <= 8'h00;
            dma_en    <= 1'b0;
            eodma     <= 1'b0;
            busy_err  <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            dma_wr_q <= dma_wr_l;
            dma_rd_q <= dma_rd_l;
            reg_wr_q <= reg_wr_l;
            reg_rd_q <= reg_rd_l;
            req_q    <= sig_req;
            bsy_q    <= any_bsy;

            if (reg_wr) begin
                case (bus_rs)
                    3'd0: scsi_dout <= wdata;
                    3'd1: begin
                        icr_rst <= wdata[7];
                        icr_lo  <= wdata[4:0];
                    end
                    3'd2: mr  <= wdata;
                    3'd3: tcr <= wdata[3:0];
                    default: ;
                endcase
            end
            if (dma_wr) scsi_dout <= wdata;
            if (bsy_loss) mr[1] <= 1'b0;

            if (dma_start) dma_en <= 1'b1;
            if (!mr[1] || mismatch || bsy_loss) dma_en <= 1'b0;

            // Set events are applied after the clear so they win a same-cycle collision
            if (rd7_clr) begin
                eodma    <= 1'b0;
                busy_err <= 1'b0;
            end
            if (mismatch) eodma    <= 1'b1;
            if (bsy_loss) busy_err <= 1'b1;

            if (ce) ack_q <= (state == D_ACK);
        end
    end

`ifdef NCR5380_MT_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (rd7_clr) irq_flag <= 1'b0;
            if (mismatch || bsy_loss) irq_flag <= 1'b1;
            irq <= irq_flag & mr[4];
        end
    end
`else
    assign irq_flag = 1'b0;
    assign irq      = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= D_IDLE;
        else       state <= state_n;
    end

    // DMA handshake sequencing
    always_comb begin
        state_n = state;
        case (state)
            D_IDLE:  if (dma_en) state_n = D_WAIT;
            D_WAIT:  if ((dma_rd | dma_wr) & sig_req) state_n = D_ACK;
            D_ACK:   if (!sig_req) state_n = D_WAIT;
            default: state_n = D_IDLE;
        endcase
        if (!dma_en) state_n = D_IDLE;
    end

    always_comb begin
        drq      = sig_req & dma_en & (state == D_WAIT);
        scsi_ack = icr_lo[4] | ack_q;
        scsi_sel = icr_lo[2];
        scsi_atn = icr_lo[1];
        scsi_rst = icr_rst;
    end

    // Host read mux; pseudo-DMA accesses always see the data port
    always_comb begin
        out_en  = icr_lo[0] | mr[0];
        csr_bsy = icr_lo[3] | any_bsy | mr[0];
        csr     = {icr_rst, csr_bsy, sig_req, sig_msg, sig_cd, sig_io, icr_lo[2], 1'b0};
        bsr     = {eodma, drq, 1'b0, irq_flag, pmatch, busy_err, icr_lo[1], scsi_ack};
        rdata   = 8'h00;
        if (dack) begin
            rdata = out_en ? scsi_dout : din;
        end else begin
            case (bus_rs)
                3'd0, 3'd6: rdata = out_en ? scsi_dout : din;
                3'd1:       rdata = {icr_rst, mr[0], 1'b0, icr_lo};
                3'd2:       rdata = mr;
                3'd3:       rdata = {4'h0, tcr};
                3'd4:       rdata = csr;
                3'd5:       rdata = bsr;
                default:    rdata = 8'hFF;
            endcase
        end
    end

endmodule

// File: tb/tb_ncr5380_mt.sv
// Directed bench for ncr5380_mt: table of bus-mux/read vectors plus DMA, mismatch, busy-loss and reset sequences.
module tb_ncr5380_mt;

`ifdef NCR5380_MT_IRQ_EN
    localparam logic [7:0] IRQ_BIT = 8'h10;
    localparam logic       IRQ_EXP = 1'b1;
`else
    localparam logic [7:0] IRQ_BIT = 8'h00;
    localparam logic       IRQ_EXP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ce;
    logic        bus_cs;
    logic        bus_we;
    logic [2:0]  bus_rs;
    logic        dack;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        irq;
    logic        drq;
    logic [2:0]  tgt_bsy, tgt_msg, tgt_cd, tgt_io, tgt_req;
    logic [23:0] tgt_dout;
    logic        scsi_rst, scsi_sel, scsi_atn, scsi_ack;
    logic [7:0]  scsi_dout;
    logic [2:0]  act_tgt;

    int n_chk = 0;
    int n_err = 0;

    ncr5380_mt #(.NUM_TGT(3), .IDLE_DATA(8'h55)) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .bus_cs(bus_cs), .bus_we(bus_we), .bus_rs(bus_rs), .dack(dack),
        .wdata(wdata), .rdata(rdata), .irq(irq), .drq(drq),
        .tgt_bsy(tgt_bsy), .tgt_msg(tgt_msg), .tgt_cd(tgt_cd), .tgt_io(tgt_io),
        .tgt_req(tgt_req), .tgt_dout(tgt_dout),
        .scsi_rst(scsi_rst), .scsi_sel(scsi_sel), .scsi_atn(scsi_atn), .scsi_ack(scsi_ack),
        .scsi_dout(scsi_dout), .act_tgt(act_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] bsy, msg, cd, io, req;
        logic [2:0] rs;
        logic [7:0] exp_rd;
        logic [2:0] exp_act;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] rs, input logic [7:0] d);
        bus_cs = 1'b1; bus_we = 1'b1; bus_rs = rs; wdata = d;
        tick();
        bus_cs = 1'b0; bus_we = 1'b0;
        tick();
    endtask

    task automatic reg_read(input logic [2:0] rs, output logic [7:0] d);
        bus_cs = 1'b1; bus_we = 1'b0; bus_rs = rs;
        #1 d = rdata;
        tick();
        bus_cs = 1'b0;
        tick();
    endtask

    function automatic logic [13:0] outs();
        return {irq, drq, scsi_rst, scsi_sel, scsi_atn, scsi_ack, act_tgt, scsi_dout[4:0]} |
               {9'd0, 2'b00, scsi_dout[7:5]};
    endfunction

    logic [7:0] rd;
    logic [7:0] bytes_q[3];

    initial begin
        // table: {bsy, msg, cd, io, req, rs, exp_rdata, exp_act}
        vt[0]  = '{3'b110, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 8'hB2, 3'd1};
        vt[1]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 8'h55, 3'd0};
        vt[2]  = '{3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'd6, 8'hC3, 3'd2};
        vt[3]  = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0, 8'hA1, 3'd0};
        vt[4]  = '{3'b110, 3'b010, 3'b000, 3'b010, 3'b010, 3'd4, 8'h74, 3'd1};
        vt[5]  = '{3'b000, 3'b111, 3'b111, 3'b111, 3'b111, 3'd4, 8'h00, 3'd0};
        vt[6]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd5, 8'h08, 3'd0};
        vt[7]  = '{3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'd5, 8'h00, 3'd0};
        vt[8]  = '{3'b111, 3'b000, 3'b100, 3'b100, 3'b000, 3'd4, 8'h40, 3'd0};
        vt[9]  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd7, 8'hFF, 3'd0};
        vt[10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1, 8'h00, 3'd0};
        bytes_q[0] = 8'h11; bytes_q[1] = 8'h22; bytes_q[2] = 8'h33;

        reset = 1'b0; ce = 1'b1; bus_cs = 1'b0; bus_we = 1'b0; bus_rs = 3'd0;
        dack = 1'b0; wdata = 8'h00;
        tgt_bsy = 3'b000; tgt_msg = 3'b000; tgt_cd = 3'b000; tgt_io = 3'b000; tgt_req = 3'b000;
        tgt_dout = {8'hC3, 8'hB2, 8'hA1};

        // Reset takes effect before any clock edge
        #3 reset = 1'b1;
        #1 chk("reset_outs", 32'(outs()), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        bus_rs = 3'd2; #1 chk("reset_mr", 32'(rdata), 32'h00);
        bus_rs = 3'd5; #1 chk("reset_bsr", 32'(rdata), 32'h08);

        for (int i = 0; i < 11; i++) begin
            tgt_bsy = vt[i].bsy; tgt_msg = vt[i].msg; tgt_cd = vt[i].cd;
            tgt_io = vt[i].io; tgt_req = vt[i].req; bus_rs = vt[i].rs;
            #1;
            chk($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vt[i].exp_rd));
            chk($sformatf("vec%0d_act", i), 32'(act_tgt), 32'(vt[i].exp_act));
            tick();
        end

        // Pseudo-DMA data-in from target 0, three bytes
        tgt_bsy = 3'b001; tgt_msg = 3'b000; tgt_cd = 3'b000; tgt_io = 3'b001; tgt_req = 3'b000;
        tick();
        reg_write(3'd2, 8'h02);
        reg_write(3'd3, 8'h01);
        reg_write(3'd7, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tgt_dout[7:0] = bytes_q[k];
            tgt_req = 3'b001;
            #1 chk($sformatf("dma%0d_drq", k), 32'(drq), 32'd1);
            tick();
            ce = 1'b0; dack = 1'b1; bus_we = 1'b0;
            #1 chk($sformatf("dma%0d_data", k), 32'(rdata), 32'(bytes_q[k]));
            tick();
            dack = 1'b0;
            #1 chk($sformatf("dma%0d_drq_ack", k), 32'(drq), 32'd0);
            tick();
            chk($sformatf("dma%0d_ack_no_ce", k), 32'(scsi_ack), 32'd0);
            ce = 1'b1;
            tick();
            chk($sformatf("dma%0d_ack_rise", k), 32'(scsi_ack), 32'd1);
            tgt_req = 3'b000;
            tick(); tick();
            chk($sformatf("dma%0d_ack_fall", k), 32'(scsi_ack), 32'd0);
        end

        // Phase mismatch: target switches to C/D while DMA is armed
        tgt_cd = 3'b001; tgt_req = 3'b001;
        tick();
        chk("pm_drq", 32'(drq), 32'd0);
        reg_read(3'd5, rd);
        chk("pm_bsr", 32'(rd), 32'(8'h80 | IRQ_BIT));
        reg_read(3'd7, rd);
        chk("pm_rs7", 32'(rd), 32'hFF);
        reg_read(3'd5, rd);
        chk("pm_bsr_clr", 32'(rd), 32'h00);

        // Clear read colliding with a new mismatch: set wins
        tgt_req = 3'b000;
        tick();
        reg_write(3'd5, 8'h00);
        bus_cs = 1'b1; bus_we = 1'b0; bus_rs = 3'd7; tgt_req = 3'b001;
        tick();
        bus_cs = 1'b0;
        tick();
        reg_read(3'd5, rd);
        chk("collide_bsr", 32'(rd), 32'(8'h80 | IRQ_BIT));
        reg_read(3'd7, rd);
        tgt_req = 3'b000; tgt_cd = 3'b000;
        tick();

        // Busy loss with MONBSY set
        reg_write(3'd2, 8'h16);
        tgt_bsy = 3'b000;
        tick(); tick();
        reg_read(3'd2, rd);
        chk("bl_mr", 32'(rd), 32'h14);
        chk("bl_irq", 32'(irq), 32'(IRQ_EXP));
        reg_read(3'd5, rd);
        chk("bl_bsr", 32'(rd), 32'(8'h04 | IRQ_BIT));

        // Manual ACK via ICR, output data, then async reset mid-write
        reg_write(3'd1, 8'h11);
        reg_write(3'd0, 8'hA5);
        chk("icr_ack", 32'(scsi_ack), 32'd1);
        chk("odr_dout", 32'(scsi_dout), 32'hA5);
        bus_rs = 3'd0; #1 chk("odr_rd", 32'(rdata), 32'hA5);
        bus_rs = 3'd1; #1 chk("icr_rd", 32'(rdata), 32'h11);
        tick();
        bus_cs = 1'b1; bus_we = 1'b1; bus_rs = 3'd0; wdata = 8'hFF;
        #1 reset = 1'b1;
        #1 chk("rst_mid_outs", 32'(outs()), 32'd0);
        bus_cs = 1'b0; bus_we = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reg_read(3'd1, rd);
        chk("rst_icr", 32'(rd), 32'h00);
        reg_read(3'd2, rd);
        chk("rst_mr", 32'(rd), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ncr5380_mt.md
NCR5380_MT -- requirements
Module: ncr5380_mt

Interface
REQ-001 Parameters SHALL be: NUM_TGT, default 2, number of attached SCSI targets (1..8); IDLE_DATA, default 8'h55, data returned when no target is busy.
REQ-002 Ports SHALL be, in order:
  clk  in  1  system clock;
  reset  in  1  asynchronous, active-high reset;
  ce  in  1  clock enable for ACK timing;
  bus_cs  in  1  chip select;
  bus_we  in  1  write strobe;
  bus_rs  in  3  register select;
  dack  in  1  pseudo-DMA access;
  wdata  in  8  host write data;
  rdata  out  8  host read data (combinational);
  irq  out  1  interrupt request;
  drq  out  1  DMA request;
  tgt_bsy, tgt_msg, tgt_cd, tgt_io, tgt_req  in  NUM_TGT each  per-target bus signals;
  tgt_dout  in  8*NUM_TGT  per-target data, target i in bits [8i+7:8i];
  scsi_rst, scsi_sel, scsi_atn, scsi_ack  out  1 each  initiator signals;
  scsi_dout  out  8  output data latch;
  act_tgt  out  3  index of the active target.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.

Function
REQ-004 Host strobes (dma_rd, dma_wr, reg_wr) SHALL be rising-edge detected and pulse for one cycle, with priority dma_wr > dma_rd > reg_wr.
REQ-005 act_tgt SHALL be the lowest index i with tgt_bsy[i]=1, or 0 when none is busy.
  The muxed msg/cd/io/req/din SHALL come from act_tgt when any target is busy.
  Otherwise msg/cd/io/req SHALL be 0 and din SHALL be IDLE_DATA.
REQ-006 Writes to ODR, ICR, MR and TCR (wdata[3:0]) SHALL update the register on the reg_wr cycle.
  scsi_dout SHALL also load on dma_wr.
REQ-007 Reads:
  dack or rs 0/6: out_en ? scsi_dout : din, where out_en = ICR[0] | MR[0];
  rs1: {ICR7, MR0, 0, ICR4:0};
  rs2: MR;
  rs3: {4'h0, TCR};
  rs4: CSR = {rst, bsy, req, msg, cd, io, sel, 0}, where bsy = ICR3 | any tgt_bsy | MR0;
  rs5: BSR = {eodma, drq, 0, irq_flag, pmatch, busy_err, atn, ack};
  rs7: SHALL clear irq_flag, eodma and busy_err one cycle after the read strobe's rising edge, and return 8'hFF.
REQ-008 dma_en SHALL set on reg_wr to rs 5, 6 or 7 while MR1=1.
  It SHALL clear whenever MR1=0, on phase mismatch, or on busy loss.
REQ-009 DMA FSM: D_IDLE -> D_WAIT when dma_en.
  D_WAIT -> D_ACK on (dma_rd | dma_wr) & req.
  D_ACK -> D_WAIT when req=0.
  Any state -> D_IDLE when dma_en=0.
REQ-010 scsi_ack SHALL equal ICR4 | ack_q, where ack_q <= (state==D_ACK) on ce cycles only.
REQ-011 drq SHALL equal req & dma_en & (state==D_WAIT).
REQ-012 Phase mismatch: req rising while dma_en and pmatch=0 SHALL set eodma, set irq_flag and clear dma_en.
REQ-013 Busy loss: an any-bsy 1->0 edge while MR2 (MONBSY)=1 SHALL set busy_err and irq_flag, and clear MR1 and dma_en.
REQ-014 If the rs7 clear and a new set event occur in the same cycle, the set SHALL win.
REQ-015 scsi_sel, scsi_atn and scsi_rst SHALL be ICR2, ICR1 and ICR7 respectively.

Reset
REQ-016 On reset assertion, with no clock required: MR, ICR, TCR, scsi_dout=0; dma_en=0; state=D_IDLE; ack_q=0; irq_flag, eodma, busy_err=0; strobe edge registers=0.
  Every output SHALL therefore be 0, except rdata (combinational).
REQ-017 Reset asserted mid-transfer SHALL drop scsi_ack and drq immediately.

Configuration
REQ-018 Macro NCR5380_MT_IRQ_EN:
  Defined: irq = irq_flag & MR4 (EIP enable), registered.
  Undefined: irq is tied 0, irq_flag logic is removed, and BSR bit4 reads 0; eodma and busy_err remain functional.

Verification
REQ-019 NUM_TGT=3, tgt_bsy=3'b110 -> act_tgt=1 and rdata(rs0, ICR=0) = tgt_dout[15:8]; tgt_bsy=0 -> rdata=8'h55.
REQ-020 MR=8'h02, write rs7, target io=1 req=1 TCR=1, three dack reads -> per byte: drq=1, scsi_ack rises on the next ce after the read, drops after req falls; 3 bytes returned in order.
REQ-021 DMA active, TCR=1, target switches to cd=1 with req rising -> BSR=8'h80|irq bit, dma_en=0, drq=0; rs7 read -> BSR bit7=0.
REQ-022 MR=8'h16, tgt_bsy 1->0 -> busy_err=1, MR reads 8'h14, irq=1 (with NCR5380_MT_IRQ_EN), irq=0 (without).
REQ-023 Write ICR=8'h11 then ODR=8'hA5 -> scsi_ack=1, rdata(rs0)=8'hA5, rdata(rs1)=8'h11; reset pulse mid-write -> all outputs 0 asynchronously.
REQ-024 rs7 read coinciding with phase mismatch -> irq_flag stays 1.
